// File: rtl/mlblocks_pkg.sv
// rtl/mlblocks_pkg.sv - shared sequencer state encoding, drain length and counter sizing
package mlblocks_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CFG     = 3'd1,
        ST_WLOAD   = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_DONE    = 3'd5
    } seq_state_e;

    localparam int DRAIN_LEN = 2;

    // One spare bit so a counter can never wrap while counting to its limit
    function automatic int cnt_width(input int limit);
        return $clog2(limit) + 1;
    endfunction

endpackage

// File: rtl/mac_sequencer_if.sv
// rtl/mac_sequencer_if.sv - weight and input stream handshakes between source and sequencer
interface mac_sequencer_if;
    logic w_valid;
    logic w_ready;
    logic i_valid;
    logic i_ready;

    modport master (output w_valid, output i_valid, input w_ready, input i_ready);
    modport slave  (input w_valid, input i_valid, output w_ready, output i_ready);
endinterface

// File: rtl/cfg_shifter.sv
// rtl/cfg_shifter.sv - LSB-first serialiser for the MAC configuration chain
module cfg_shifter
    import mlblocks_pkg::*;
#(
    parameter int LEN = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic [LEN-1:0] din,
    input  logic           shift,
    output logic           bit_out,
    output logic           done
);
    localparam int CW = cnt_width(LEN);

    logic [LEN-1:0] sr_q, sr_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load) begin
            sr_d  = din;
            cnt_d = '0;
        end else if (shift) begin
            sr_d  = sr_q >> 1;
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign bit_out = sr_q[0];
    assign done    = shift & (cnt_q == CW'(LEN - 1));

endmodule

// File: rtl/mac_sequencer.sv
// rtl/mac_sequencer.sv - job sequencer: config chain, weight load, vector compute, drain
module mac_sequencer
    import mlblocks_pkg::*;
#(
    parameter int CFG_LEN     = 16,
    parameter int W_D         = 4,
    parameter int LEN_W       = 16,
    parameter int N_OF_COFIGS = 4,
    localparam int CFG_SEL_W  = $clog2(N_OF_COFIGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CFG_LEN-1:0]   cfg_word,
    input  logic [CFG_SEL_W-1:0] cfg_sel,
    input  logic [LEN_W-1:0]     n_vec,
    input  logic                 hp_req,
    mac_sequencer_if.slave       strm,
    output logic [CFG_SEL_W-1:0] configg,
    output logic                 config_en,
    output logic                 config_in,
    output logic                 W_en,
    output logic                 I_en,
    output logic                 Res_en,
    output logic                 hp_en,
    output logic                 busy,
    output logic                 done
);
    localparam int WCW = cnt_width(W_D);
    localparam int DCW = cnt_width(DRAIN_LEN);

    seq_state_e           state_q, state_d;
    logic [WCW-1:0]       w_cnt_q, w_cnt_d;
    logic [LEN_W-1:0]     v_cnt_q, v_cnt_d;
    logic [DCW-1:0]       d_cnt_q, d_cnt_d;
    logic [LEN_W-1:0]     n_vec_q, n_vec_d;
    logic                 hp_q, hp_d;
    logic [CFG_SEL_W-1:0] sel_q, sel_d;
    logic busy_q, busy_d, done_q, done_d, cfg_en_q, cfg_en_d;
    logic w_ready_q, w_ready_d, i_ready_q, i_ready_d;
    logic drain_q, drain_d, hp_en_q, hp_en_d;
    logic shift_load, shift_en, shift_bit, shift_last, w_hs, i_hs;

    assign w_hs = strm.w_valid & w_ready_q;
    assign i_hs = strm.i_valid & i_ready_q;

    cfg_shifter #(.LEN(CFG_LEN)) u_cfg_shifter (
        .clk     (clk),
        .reset   (reset),
        .load    (shift_load),
        .din     (cfg_word),
        .shift   (shift_en),
        .bit_out (shift_bit),
        .done    (shift_last)
    );

    always_comb begin
        state_d    = state_q;
        w_cnt_d    = w_cnt_q;
        v_cnt_d    = v_cnt_q;
        d_cnt_d    = d_cnt_q;
        n_vec_d    = n_vec_q;
        hp_d       = hp_q;
        sel_d      = sel_q;
        shift_load = 1'b0;
        shift_en   = (state_q == ST_CFG);
        unique case (state_q)
            ST_IDLE: if (start) begin
                state_d    = ST_CFG;
                n_vec_d    = n_vec;
                hp_d       = hp_req;
                sel_d      = cfg_sel;
                shift_load = 1'b1;
                w_cnt_d    = '0;
                v_cnt_d    = '0;
                d_cnt_d    = '0;
            end
            ST_CFG: if (shift_last) state_d = ST_WLOAD;
            ST_WLOAD: if (w_hs) begin
                if (w_cnt_q == WCW'(W_D - 1))
                    state_d = (n_vec_q == '0) ? ST_DRAIN : ST_COMPUTE;
                else
                    w_cnt_d = w_cnt_q + WCW'(1);
            end
            ST_COMPUTE: if (i_hs) begin
                if (v_cnt_q == n_vec_q - LEN_W'(1)) state_d = ST_DRAIN;
                else                                v_cnt_d = v_cnt_q + LEN_W'(1);
            end
            ST_DRAIN: begin
                if (d_cnt_q == DCW'(DRAIN_LEN - 1)) state_d = ST_DONE;
                else                                d_cnt_d = d_cnt_q + DCW'(1);
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort && state_q != ST_IDLE) state_d = ST_IDLE;

        // Outputs are decoded from the next state so they leave the block as flops
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
        cfg_en_d  = (state_d == ST_CFG);
        w_ready_d = (state_d == ST_WLOAD);
        i_ready_d = (state_d == ST_COMPUTE);
        drain_d   = (state_d == ST_DRAIN);
        hp_en_d   = hp_d & (w_ready_d | i_ready_d | drain_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            w_cnt_q   <= '0;
            v_cnt_q   <= '0;
            d_cnt_q   <= '0;
            n_vec_q   <= '0;
            hp_q      <= 1'b0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_en_q  <= 1'b0;
            w_ready_q <= 1'b0;
            i_ready_q <= 1'b0;
            drain_q   <= 1'b0;
            hp_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            w_cnt_q   <= w_cnt_d;
            v_cnt_q   <= v_cnt_d;
            d_cnt_q   <= d_cnt_d;
            n_vec_q   <= n_vec_d;
            hp_q      <= hp_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cfg_en_q  <= cfg_en_d;
            w_ready_q <= w_ready_d;
            i_ready_q <= i_ready_d;
            drain_q   <= drain_d;
            hp_en_q   <= hp_en_d;
        end
    end

    assign strm.w_ready = w_ready_q;
    assign strm.i_ready = i_ready_q;
    assign configg      = sel_q;
    assign config_en    = cfg_en_q;
    assign config_in    = cfg_en_q & shift_bit;
    assign W_en         = w_hs;
    assign I_en         = i_hs;
    assign Res_en       = drain_q | i_hs;
    assign hp_en        = hp_en_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// tb/tb_mac_sequencer.sv - table, randomized and corner-case checks of mac_sequencer
module tb_mac_sequencer;

    localparam int CFG_LEN = 16;
    localparam int W_D     = 4;
    localparam int LEN_W   = 6;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, hp_req = 1'b0;
    logic [15:0] cfg_word = '0;
    logic [1:0]  cfg_sel = '0;
    logic [5:0]  n_vec = '0;
    logic [1:0]  configg;
    logic config_en, config_in, W_en, I_en, Res_en, hp_en, busy, done;
    int cmp_cnt = 0;
    int err_cnt = 0;

    mac_sequencer_if sif ();

    mac_sequencer #(.CFG_LEN(CFG_LEN), .W_D(W_D), .LEN_W(LEN_W), .N_OF_COFIGS(4)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .cfg_word(cfg_word),
        .cfg_sel(cfg_sel), .n_vec(n_vec), .hp_req(hp_req), .strm(sif.slave),
        .configg(configg), .config_en(config_en), .config_in(config_in), .W_en(W_en),
        .I_en(I_en), .Res_en(Res_en), .hp_en(hp_en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic wv; logic iv; logic [9:0] exp; } step_t;
    typedef struct { logic [15:0] cw; logic [1:0] sel; logic [5:0] nv; logic hp; int e_i; int e_r; int e_done; } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic rnd(input int pct);
        return ($urandom_range(99) < pct);
    endfunction

    function automatic logic [9:0] pk(input logic b, dn, ce, ci, wr, ir, we, ie, re, hp);
        return {b, dn, ce, ci, wr, ir, we, ie, re, hp};
    endfunction

    function automatic logic [9:0] outs();
        return {busy, done, config_en, config_in, sif.w_ready, sif.i_ready, W_en, I_en, Res_en, hp_en};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string nm, input int bound);
        logic seen = 1'b0;
        for (int c = 0; c < bound && !seen; c++) begin
            @(negedge clk);
            seen = done;
            step();
        end
        check(nm, 32'(seen), 32'(1));
    endtask

    // Expected job timeline built phase by phase: config bits, weight words, vectors, drain, done, idle
    task automatic run_job(input logic [15:0] cw, input logic [1:0] sel, input logic [5:0] nv, input logic hpv,
                           input int wb, input int ib, output int n_w, output int n_i, output int n_r,
                           output int done_at, output logic [15:0] bits);
        step_t q[$];
        step_t s;
        int acc, k;
        logic v;
        for (int b = 0; b < CFG_LEN; b++) begin
            s.wv = rnd(50); s.iv = rnd(50); s.exp = pk(1, 0, 1, cw[b], 0, 0, 0, 0, 0, 0);
            q.push_back(s);
        end
        acc = 0;
        while (acc < W_D) begin
            v = rnd(wb);
            s.wv = v; s.iv = rnd(50); s.exp = pk(1, 0, 0, 0, 1, 0, v, 0, 0, hpv);
            q.push_back(s);
            acc += int'(v);
        end
        acc = 0;
        while (acc < int'(nv)) begin
            v = rnd(ib);
            s.wv = rnd(50); s.iv = v; s.exp = pk(1, 0, 0, 0, 0, 1, 0, v, v, hpv);
            q.push_back(s);
            acc += int'(v);
        end
        for (int d = 0; d < 2; d++) begin
            s.wv = rnd(50); s.iv = rnd(50); s.exp = pk(1, 0, 0, 0, 0, 0, 0, 0, 1, hpv);
            q.push_back(s);
        end
        s.wv = rnd(50); s.iv = rnd(50); s.exp = pk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        q.push_back(s);
        s.wv = 1'b0; s.iv = 1'b0; s.exp = '0;
        q.push_back(s);

        cfg_word = cw; cfg_sel = sel; n_vec = nv; hp_req = hpv; start = 1'b1; abort = rnd(50);
        sif.w_valid = 1'b0; sif.i_valid = 1'b0;
        @(negedge clk);
        check("idle_before_start", 32'(outs()), 32'(0));
        step();
        abort = 1'b0;
        n_w = 0; n_i = 0; n_r = 0; done_at = -1; bits = '0; k = 0;
        for (int i = 0; i < q.size(); i++) begin
            sif.w_valid = q[i].wv;
            sif.i_valid = q[i].iv;
            start    = (i + 1 < q.size()) ? rnd(15) : 1'b0;
            cfg_word = 16'($urandom);
            cfg_sel  = 2'($urandom);
            n_vec    = 6'($urandom);
            hp_req   = rnd(50);
            @(negedge clk);
            check($sformatf("trace[%0d]", i), 32'(outs()), 32'(q[i].exp));
            n_w += int'(W_en);
            n_i += int'(I_en);
            n_r += int'(Res_en);
            if (config_en && k < 16) begin
                bits[k] = config_in;
                k++;
            end
            if (done) done_at = i + 1;
            step();
        end
        check("configg", 32'(configg), 32'(sel));
        sif.w_valid = 1'b0;
        sif.i_valid = 1'b0;
    endtask

    vec_t tbl[4];
    int nw, ni, nr, da;
    logic [15:0] bits;
    logic quiet;
    int pat[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sif.w_valid = 1'b0;
        sif.i_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("reset_outs", 32'(outs()), 32'(0));
        check("reset_configg", 32'(configg), 32'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        tbl[0] = '{16'hA5C3, 2'd1, 6'd3,  1'b1, 3,  5,  26};
        tbl[1] = '{16'hFFFF, 2'd3, 6'd0,  1'b0, 0,  2,  23};
        tbl[2] = '{16'h0001, 2'd2, 6'd1,  1'b1, 1,  3,  24};
        tbl[3] = '{16'h8000, 2'd0, 6'd63, 1'b0, 63, 65, 86};
        for (int t = 0; t < 4; t++) begin
            run_job(tbl[t].cw, tbl[t].sel, tbl[t].nv, tbl[t].hp, 100, 100, nw, ni, nr, da, bits);
            check("tbl_w_en", 32'(nw), 32'(4));
            check("tbl_i_en", 32'(ni), 32'(tbl[t].e_i));
            check("tbl_res_en", 32'(nr), 32'(tbl[t].e_r));
            check("tbl_done_at", 32'(da), 32'(tbl[t].e_done));
            check("tbl_cfg_bits", 32'(bits), 32'(tbl[t].cw));
        end

        for (int j = 0; j < 8; j++) begin
            logic [15:0] cw;
            logic [5:0] nv;
            cw = 16'($urandom);
            nv = 6'($urandom_range(0, 12));
            run_job(cw, 2'($urandom), nv, rnd(50), int'($urandom_range(30, 90)),
                    int'($urandom_range(30, 90)), nw, ni, nr, da, bits);
            check("rnd_w_en", 32'(nw), 32'(4));
            check("rnd_i_en", 32'(ni), 32'(nv));
            check("rnd_res_en", 32'(nr), 32'(nv) + 32'(2));
            check("rnd_cfg_bits", 32'(bits), 32'(cw));
        end

        // Stalled weight stream: words accepted only on valid, COMPUTE right after the 4th
        pat = '{1, 0, 1, 1, 0, 1};
        cfg_word = 16'h1234; cfg_sel = 2'd1; n_vec = 6'd1; hp_req = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (16) step();
        for (int p = 0; p < 6; p++) begin
            sif.w_valid = pat[p][0];
            @(negedge clk);
            check("stall_w_en", 32'({sif.w_ready, W_en}), 32'({1'b1, pat[p][0]}));
            step();
        end
        sif.w_valid = 1'b1;
        @(negedge clk);
        check("stall_to_compute", 32'({sif.w_ready, sif.i_ready, W_en}), 32'(3'b010));
        step();
        sif.i_valid = 1'b1;
        wait_done("stall_done", 20);
        sif.w_valid = 1'b0; sif.i_valid = 1'b0;

        // Abort after the first accepted vector
        cfg_word = 16'h0F0F; cfg_sel = 2'd2; n_vec = 6'd5; hp_req = 1'b1;
        sif.w_valid = 1'b1; sif.i_valid = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        repeat (20) step();
        @(negedge clk);
        check("abort_first_vec", 32'({I_en, Res_en, hp_en}), 32'(3'b111));
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        check("abort_outs", 32'(outs()), 32'(0));
        step();
        quiet = 1'b0;
        repeat (8) begin
            @(negedge clk);
            quiet = quiet | done | busy;
            step();
        end
        check("abort_quiet", 32'(quiet), 32'(0));
        run_job(16'h5A5A, 2'd3, 6'd2, 1'b1, 100, 100, nw, ni, nr, da, bits);
        check("after_abort_i_en", 32'(ni), 32'(2));
        check("after_abort_done_at", 32'(da), 32'(25));

        // Asynchronous reset in the middle of WLOAD, then an immediate new job
        cfg_word = 16'h3C5A; cfg_sel = 2'd3; n_vec = 6'd2; hp_req = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        repeat (18) step();
        @(negedge clk);
        check("pre_reset_wload", 32'({busy, sif.w_ready, hp_en}), 32'(3'b111));
        #2 reset = 1'b0;
        #1;
        check("reset_async_outs", 32'(outs()), 32'(0));
        check("reset_async_configg", 32'(configg), 32'(0));
        step();
        reset = 1'b1;
        cfg_word = 16'h0001; cfg_sel = 2'd1; start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        check("post_reset_cfg", 32'({busy, config_en, config_in}), 32'(3'b111));
        step();
        sif.w_valid = 1'b1; sif.i_valid = 1'b1;
        wait_done("post_reset_done", 60);
        sif.w_valid = 1'b0; sif.i_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 Parameter CFG_LEN, default 16, SHALL set the number of configuration bits shifted into the MAC serial config chain.
REQ-002 Parameter W_D, default 4, SHALL set the number of weight words loaded per job.
REQ-003 Parameter LEN_W, default 16, SHALL set the width of the vector-count field.
REQ-004 Parameter N_OF_COFIGS, default 4, SHALL set the number of input/result source configurations; CFG_SEL_W = $clog2(N_OF_COFIGS).
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle job request, sampled only in IDLE.
REQ-008 abort  in  1  cancels the current job.
REQ-009 cfg_word  in  CFG_LEN  config bits, captured on accepted start.
REQ-010 cfg_sel  in  CFG_SEL_W  source select, captured on accepted start.
REQ-011 n_vec  in  LEN_W  number of input vectors to stream, captured on accepted start.
REQ-012 hp_req  in  1  high-precision request, captured on accepted start.
REQ-013 w_valid / w_ready  in / out  1 / 1  weight-stream handshake.
REQ-014 i_valid / i_ready  in / out  1 / 1  input-stream handshake.
REQ-015 configg  out  CFG_SEL_W  registered copy of cfg_sel.
REQ-016 config_en, config_in  out  1, 1  serial config chain drive.
REQ-017 W_en, I_en, Res_en, hp_en  out  1 each  MAC enables.
REQ-018 busy, done  out  1, 1  job active; one-cycle completion pulse.

Function
REQ-019 States SHALL be IDLE, CFG, WLOAD, COMPUTE, DRAIN, DONE.
REQ-020 IDLE->CFG on start; start outside IDLE SHALL be ignored.
REQ-021 CFG: config_en=1 for exactly CFG_LEN cycles, config_in = captured cfg_word bit k in the k-th cycle (LSB first); then ->WLOAD.
REQ-022 WLOAD: w_ready=1; W_en = w_valid & w_ready; after the W_D-th accepted word ->COMPUTE (or ->DRAIN if n_vec==0).
REQ-023 COMPUTE: i_ready=1; I_en = i_valid & i_ready; Res_en=1 in every cycle where I_en=1; after the n_vec-th accepted vector ->DRAIN.
REQ-024 DRAIN: Res_en=1 for exactly 2 cycles, I_en=W_en=0; then ->DONE.
REQ-025 DONE: done=1 for one cycle; ->IDLE.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 hp_en SHALL equal captured hp_req in WLOAD, COMPUTE, DRAIN, else 0.
REQ-028 Handshake stalls (valid low) SHALL hold the state and counters; no enable pulses without a handshake.
REQ-029 abort in any non-IDLE state SHALL force IDLE next cycle with all enables, ready and done low; abort in IDLE has no effect; abort wins over any same-cycle transition.
REQ-030 Vector counter SHALL be LEN_W bits, counting up to n_vec with no wrap; n_vec = 2^LEN_W-1 SHALL complete correctly.
REQ-031 Word and bit counters SHALL be sized $clog2 of their limits plus one, never wrapping within a job.

Reset
REQ-032 On reset low, state SHALL be IDLE and all outputs 0 (configg=0) immediately, independent of clk.
REQ-033 Reset assertion mid-job SHALL discard the job; after release the block SHALL accept a new start on the first clk edge.

Structure
REQ-034 State enum and the DRAIN length constant (2) SHALL live in shared package mlblocks_pkg.
REQ-035 Serial config shifter SHALL be one sub-module, cfg_shifter (load, shift, bit out, done).

Verification
REQ-036 start, cfg_word=16'hA5C3 -> config_in bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 over 16 config_en cycles.
REQ-037 W_D=4, w_valid toggling 1,0,1,1,0,1 -> exactly 4 W_en pulses, COMPUTE entered the cycle after the 4th.
REQ-038 n_vec=3, i_valid continuous -> 3 I_en pulses, 5 Res_en cycles total, done one cycle after DRAIN.
REQ-039 n_vec=0 -> zero I_en, WLOAD->DRAIN->DONE, done asserted.
REQ-040 abort in COMPUTE after 1 vector -> next cycle IDLE, busy=0, done never asserted; new start then runs a full job.
REQ-041 reset low mid-WLOAD -> outputs 0 asynchronously; start after release begins CFG on the next edge.
